// File: rtl/eq_band_scheduler_pkg.sv
// Shared types, widths and helpers for the equalizer band scheduler.
package eq_pkg;

  localparam int NUM_BANDS = 5;
  localparam int COEF_W    = 18;
  localparam int DATA_W    = 16;
  localparam int GAIN_W    = 8;
  localparam int ACC_W     = 27;
  localparam int BAND_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } eq_state_t;

  typedef enum logic [2:0] {
    CFG_B1   = 3'd0,
    CFG_B2   = 3'd1,
    CFG_B3   = 3'd2,
    CFG_A2   = 3'd3,
    CFG_A3   = 3'd4,
    CFG_GAIN = 3'd5
  } cfg_sel_t;

  // One band's full parameter set as stored in the shadow and active banks.
  typedef struct packed {
    logic [COEF_W-1:0] b1;
    logic [COEF_W-1:0] b2;
    logic [COEF_W-1:0] b3;
    logic [COEF_W-1:0] a2;
    logic [COEF_W-1:0] a3;
    logic [GAIN_W-1:0] gain;
  } coef_set_t;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > 27'sd32767) begin
      r = 16'sh7fff;
    end else if (v < -27'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_band_scheduler_if.sv
// Request/response bus between the band scheduler and the shared biquad core.
interface eq_bq_if;
  import eq_pkg::*;

  logic                     o_bq_start;
  logic [BAND_W-1:0]        o_bq_band;
  logic signed [DATA_W-1:0] o_bq_x;
  logic signed [COEF_W-1:0] o_b1;
  logic signed [COEF_W-1:0] o_b2;
  logic signed [COEF_W-1:0] o_b3;
  logic signed [COEF_W-1:0] o_a2;
  logic signed [COEF_W-1:0] o_a3;
  logic                     i_bq_done;
  logic signed [DATA_W-1:0] i_bq_y;

  modport master (
    output o_bq_start, o_bq_band, o_bq_x, o_b1, o_b2, o_b3, o_a2, o_a3,
    input  i_bq_done, i_bq_y
  );

  modport slave (
    input  o_bq_start, o_bq_band, o_bq_x, o_b1, o_b2, o_b3, o_a2, o_a3,
    output i_bq_done, i_bq_y
  );

endinterface

// File: rtl/eq_band_scheduler_coef_bank.sv
// Shadow/active coefficient and gain storage with config decode and band read mux.
module eq_coef_bank #(
  parameter int NUM_BANDS = eq_pkg::NUM_BANDS
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_we,
  input  logic [eq_pkg::BAND_W-1:0] i_cfg_band,
  input  logic [2:0]                i_cfg_sel,
  input  logic [eq_pkg::COEF_W-1:0] i_cfg_data,
  input  logic                      i_load,
  input  logic [eq_pkg::BAND_W-1:0] i_rd_band,
  output eq_pkg::coef_set_t         o_set
);
  import eq_pkg::*;

  coef_set_t shadow_q [NUM_BANDS];
  coef_set_t active_q [NUM_BANDS];
  logic      wr_ok_s;

  // A write is accepted only for an existing band and a defined field.
  assign wr_ok_s = i_cfg_we && (32'(i_cfg_band) < NUM_BANDS) && (i_cfg_sel <= 3'd5);

  // Copy shadow to active on load; a same-cycle write lands in shadow after the copy.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        shadow_q[b] <= '0;
        active_q[b] <= '0;
      end
    end else begin
      if (i_load) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          active_q[b] <= shadow_q[b];
        end
      end
      if (wr_ok_s) begin
        case (cfg_sel_t'(i_cfg_sel))
          CFG_B1:   shadow_q[i_cfg_band].b1   <= i_cfg_data;
          CFG_B2:   shadow_q[i_cfg_band].b2   <= i_cfg_data;
          CFG_B3:   shadow_q[i_cfg_band].b3   <= i_cfg_data;
          CFG_A2:   shadow_q[i_cfg_band].a2   <= i_cfg_data;
          CFG_A3:   shadow_q[i_cfg_band].a3   <= i_cfg_data;
          CFG_GAIN: shadow_q[i_cfg_band].gain <= i_cfg_data[GAIN_W-1:0];
          default:  ;
        endcase
      end
    end
  end

  assign o_set = active_q[i_rd_band];

endmodule

// File: rtl/eq_band_scheduler.sv
// Sequences one shared biquad core over all bands per sample and sums gained outputs.
module eq_band_scheduler #(
  parameter int NUM_BANDS = eq_pkg::NUM_BANDS,
  parameter int COEF_W    = eq_pkg::COEF_W,
  parameter int DATA_W    = eq_pkg::DATA_W,
  parameter int GAIN_W    = eq_pkg::GAIN_W
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     lrclk_negedge,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] audio_in,
  input  logic                     i_cfg_we,
  input  logic [2:0]               i_cfg_band,
  input  logic [2:0]               i_cfg_sel,
  input  logic [COEF_W-1:0]        i_cfg_data,
  eq_bq_if.master                  bq,
  output logic signed [DATA_W-1:0] audio_out,
  output logic                     o_out_valid,
  output logic                     o_overrun
);
  import eq_pkg::*;

  localparam int LAST_BAND = NUM_BANDS - 1;

  eq_state_t                state_q, state_d;
  logic [BAND_W-1:0]        band_q, band_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] audio_q, audio_d;
  logic                     start_q, out_valid_q, overrun_q;
  logic                     load_s;
  coef_set_t                cur_s;
  logic signed [DATA_W+GAIN_W:0] prod_s;

  eq_coef_bank #(.NUM_BANDS(NUM_BANDS)) u_bank (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_band (i_cfg_band),
    .i_cfg_sel  (i_cfg_sel),
    .i_cfg_data (i_cfg_data),
    .i_load     (load_s),
    .i_rd_band  (band_q),
    .o_set      (cur_s)
  );

  // Gain is unsigned Q1.7, so widen it with a zero sign bit before the signed multiply.
  assign prod_s = bq.i_bq_y * $signed({1'b0, cur_s.gain});

  // Next-state, band/accumulator updates and bank load request.
  always_comb begin
    state_d = state_q;
    band_d  = band_q;
    x_d     = x_q;
    acc_d   = acc_q;
    audio_d = audio_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lrclk_negedge && i_valid) begin
          x_d     = audio_in;
          acc_d   = '0;
          band_d  = '0;
          load_s  = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bq.i_bq_done) begin
          acc_d = acc_q + ACC_W'(prod_s);
          if (band_q == BAND_W'(LAST_BAND)) begin
            state_d = ST_FINISH;
          end else begin
            band_d  = band_q + 3'd1;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FINISH: begin
        audio_d = sat16(acc_q >>> 7);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; strobes outside IDLE only raise the sticky overrun.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      band_q      <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      audio_q     <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      audio_q     <= audio_d;
      start_q     <= (state_d == ST_ISSUE);
      out_valid_q <= (state_q == ST_FINISH);
      overrun_q   <= overrun_q | (lrclk_negedge && (state_q != ST_IDLE));
    end
  end

  assign bq.o_bq_start = start_q;
  assign bq.o_bq_band  = band_q;
  assign bq.o_bq_x     = x_q;
  assign bq.o_b1       = cur_s.b1;
  assign bq.o_b2       = cur_s.b2;
  assign bq.o_b3       = cur_s.b3;
  assign bq.o_a2       = cur_s.a2;
  assign bq.o_a3       = cur_s.a3;
  assign audio_out     = audio_q;
  assign o_out_valid   = out_valid_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Scoreboard bench for eq_band_scheduler with a behavioural y = x biquad core.
module tb_eq_band_scheduler;
  import eq_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               lrclk;
  logic               valid;
  logic signed [15:0] audio_in;
  logic               cfg_we;
  logic [2:0]         cfg_band;
  logic [2:0]         cfg_sel;
  logic [17:0]        cfg_data;
  logic signed [15:0] audio_out;
  logic               out_valid;
  logic               overrun;

  eq_bq_if bq();

  eq_band_scheduler dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .lrclk_negedge (lrclk),
    .i_valid       (valid),
    .audio_in      (audio_in),
    .i_cfg_we      (cfg_we),
    .i_cfg_band    (cfg_band),
    .i_cfg_sel     (cfg_sel),
    .i_cfg_data    (cfg_data),
    .bq            (bq),
    .audio_out     (audio_out),
    .o_out_valid   (out_valid),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Bench model of the coefficient banks (only gain and b1 are exercised).
  int     sh_gain [8];
  int     act_gain[8];
  longint sh_b1   [8];
  longint act_b1  [8];

  int     exp_band_q [$];
  longint exp_x_q    [$];
  longint exp_audio_q[$];

  int core_lat      = 3;
  int last_done_cyc = -100;
  int strobe_cyc    = -100;
  int n_starts      = 0;
  int n_outs        = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_audio(input longint x);
    longint s = 0;
    for (int b = 0; b < 5; b++) s += x * act_gain[b];
    s = s >>> 7;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 8; b++) begin
      sh_gain[b] = 0; act_gain[b] = 0; sh_b1[b] = 0; act_b1[b] = 0;
    end
  endtask

  task automatic cfg_write(input int band, input int sel, input int data);
    logic [17:0] d18;
    @(posedge clk); #1;
    d18 = 18'(data);
    cfg_we = 1'b1; cfg_band = 3'(band); cfg_sel = 3'(sel); cfg_data = d18;
    if (band < 5 && sel == 0) sh_b1[band] = longint'($signed(d18));
    if (band < 5 && sel == 5) sh_gain[band] = int'(d18[7:0]);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_strobe(input int x, input logic v, input bit accept);
    @(posedge clk); #1;
    lrclk = 1'b1; valid = v; audio_in = 16'(x);
    if (accept) begin
      strobe_cyc = cyc;
      for (int b = 0; b < 8; b++) begin
        act_gain[b] = sh_gain[b]; act_b1[b] = sh_b1[b];
      end
      for (int b = 0; b < 5; b++) begin
        exp_band_q.push_back(b); exp_x_q.push_back(longint'(x));
      end
      exp_audio_q.push_back(exp_audio(longint'(x)));
    end
    @(posedge clk); #1;
    lrclk = 1'b0; valid = 1'b0;
  endtask

  task automatic wait_outs(input int target, input int budget);
    for (int i = 0; i < budget && n_outs < target; i++) @(posedge clk);
    check_val("out_timeout", longint'(n_outs >= target), 1);
  endtask

  // Behavioural biquad core: y = x after core_lat cycles.
  initial begin
    logic signed [15:0] xin;
    bq.i_bq_done = 1'b0;
    bq.i_bq_y    = '0;
    forever begin
      @(negedge clk);
      if (bq.o_bq_start === 1'b1) begin
        xin = bq.o_bq_x;
        repeat (core_lat) @(posedge clk);
        #1 bq.i_bq_done = 1'b1; bq.i_bq_y = xin;
        @(posedge clk);
        #1 bq.i_bq_done = 1'b0;
      end
    end
  end

  // Output monitor: pops scoreboards on each request and each result.
  initial begin
    int     b;
    longint xe;
    forever begin
      @(negedge clk);
      if (bq.i_bq_done === 1'b1) last_done_cyc = cyc;
      if (bq.o_bq_start === 1'b1) begin
        n_starts++;
        if (exp_band_q.size() == 0) begin
          check_val("unexpected_start", 1, 0);
        end else begin
          b  = exp_band_q.pop_front();
          xe = exp_x_q.pop_front();
          check_val("bq_band", longint'(bq.o_bq_band), longint'(b));
          check_val("bq_x", longint'(bq.o_bq_x), xe);
          check_val("bq_b1", longint'(bq.o_b1), act_b1[b]);
          if (b == 0) check_val("start_latency", longint'(cyc - strobe_cyc), 1);
        end
      end
      if (out_valid === 1'b1) begin
        n_outs++;
        if (exp_audio_q.size() == 0) begin
          check_val("unexpected_out", 1, 0);
        end else begin
          check_val("audio_out", longint'(audio_out), exp_audio_q.pop_front());
          check_val("out_latency", longint'(cyc - last_done_cyc), 2);
        end
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; lrclk = 1'b0; valid = 1'b0; audio_in = '0;
    cfg_we = 1'b0; cfg_band = '0; cfg_sel = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_audio_out", longint'(audio_out), 0);
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_start", longint'(bq.o_bq_start), 0);
    check_val("rst_overrun", longint'(overrun), 0);
    check_val("rst_band", longint'(bq.o_bq_band), 0);
    check_val("rst_x", longint'(bq.o_bq_x), 0);
    check_val("rst_b1", longint'(bq.o_b1), 0);
    rst_n = 1'b1;

    // Single band unity path.
    core_lat = 3;
    cfg_write(0, 5, 128);
    do_strobe(1000, 1'b1, 1'b1);
    wait_outs(1, 200);
    repeat (3) @(negedge clk);
    check_val("held_band", longint'(bq.o_bq_band), 4);
    check_val("held_audio", longint'(audio_out), 1000);

    // Positive and negative saturation.
    cfg_write(1, 5, 128);
    do_strobe(20000, 1'b1, 1'b1);
    wait_outs(2, 200);
    do_strobe(-20000, 1'b1, 1'b1);
    wait_outs(3, 200);

    // Invalid config writes are ignored.
    cfg_write(7, 5, 128);
    cfg_write(5, 5, 128);
    cfg_write(0, 6, 0);
    cfg_write(0, 7, 0);
    do_strobe(300, 1'b1, 1'b1);
    wait_outs(4, 200);

    // Strobe without valid is ignored.
    base = n_starts;
    do_strobe(5000, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    check_val("gated_starts", longint'(n_starts - base), 0);
    check_val("gated_outs", longint'(n_outs), 4);

    // Coefficient shadowing: write b1 of band 2 during WAIT.
    core_lat = 20;
    do_strobe(100, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    cfg_write(2, 0, 32'h10000);
    wait_outs(5, 400);
    do_strobe(100, 1'b1, 1'b1);
    wait_outs(6, 400);

    // Overrun with long core latency.
    cfg_write(1, 5, 0);
    core_lat = 100;
    do_strobe(1000, 1'b1, 1'b1);
    repeat (196) @(posedge clk);
    #1 check_val("overrun_before", longint'(overrun), 0);
    do_strobe(1234, 1'b1, 1'b0);
    @(negedge clk);
    check_val("overrun_set", longint'(overrun), 1);
    wait_outs(7, 800);
    repeat (4) @(negedge clk);
    check_val("overrun_sticky", longint'(overrun), 1);

    // Reset in WAIT at band 2.
    core_lat = 30;
    base = n_starts;
    do_strobe(777, 1'b1, 1'b1);
    for (int i = 0; i < 300 && n_starts < base + 3; i++) @(posedge clk);
    check_val("band2_reached", longint'(n_starts - base), 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_start", longint'(bq.o_bq_start), 0);
    check_val("mid_rst_band", longint'(bq.o_bq_band), 0);
    check_val("mid_rst_x", longint'(bq.o_bq_x), 0);
    check_val("mid_rst_b1", longint'(bq.o_b1), 0);
    check_val("mid_rst_audio", longint'(audio_out), 0);
    check_val("mid_rst_valid", longint'(out_valid), 0);
    check_val("mid_rst_overrun", longint'(overrun), 0);
    exp_band_q.delete(); exp_x_q.delete(); exp_audio_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    check_val("no_out_after_rst", longint'(n_outs), 7);
    core_lat = 3;
    cfg_write(0, 5, 128);
    do_strobe(-500, 1'b1, 1'b1);
    wait_outs(8, 200);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eq_band_scheduler.md
# eq_band_scheduler

Time-multiplexing controller that shares one biquad IIR core among `NUM_BANDS` equalizer bands within each audio sample period. On every sample strobe it feeds the captured sample through the core once per band, applying that band's coefficient set. It weights each band output by a per-band gain, sums the results, and emits one saturated 16-bit sample. It sits between the I2S receive path and the DAC path, and replaces one hard-wired filter instance per band.

## Interface
Parameters:
- `NUM_BANDS`, 5: number of bands sequenced per sample (2..8).
- `COEF_W`, 18: coefficient width, signed Q2.16.
- `DATA_W`, 16: audio sample width, signed.
- `GAIN_W`, 8: band gain width, unsigned Q1.7 (128 = 1.0).

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `lrclk_negedge`  in  1  one-cycle sample strobe.
- `i_valid`  in  1  `audio_in` valid qualifier.
- `audio_in`  in  16  signed input sample.
- `i_cfg_we`  in  1  config write strobe.
- `i_cfg_band`  in  3  band index of the write.
- `i_cfg_sel`  in  3  field select: 0=b1, 1=b2, 2=b3, 3=a2, 4=a3, 5=gain.
- `i_cfg_data`  in  18  write data; gain uses bits [7:0].
- `o_bq_start`  out  1  one-cycle request to the biquad core.
- `o_bq_band`  out  3  band index; the core selects its delay-state slot with it.
- `o_bq_x`  out  16  sample to filter.
- `o_b1`, `o_b2`, `o_b3`, `o_a2`, `o_a3`  out  18 each  coefficients for `o_bq_band`.
- `i_bq_done`  in  1  one-cycle completion from the core.
- `i_bq_y`  in  16  core output; valid with `i_bq_done`.
- `audio_out`  out  16  equalized sample, held between updates.
- `o_out_valid`  out  1  one-cycle pulse when `audio_out` updates.
- `o_overrun`  out  1  sticky; set when a strobe arrives while busy.

## Operation
- **Coefficient storage.** Two copies exist: a shadow bank, written by the config port, and an active bank, used by the sequencer.
  - A write with `i_cfg_band` ≥ `NUM_BANDS` or `i_cfg_sel` > 5 is ignored.
  - Shadow is copied to active only on an accepted strobe, in the same cycle `audio_in` is captured.
  - A write in that same cycle lands in shadow, after the copy, so it takes effect on the next sample.
- **FSM states:** IDLE, ISSUE, WAIT, FINISH.
  - **IDLE:** `lrclk_negedge && i_valid` captures `x_reg <= audio_in`, clears the accumulator, sets `band <= 0`, loads active from shadow, then goes to ISSUE. `lrclk_negedge` without `i_valid` is ignored.
  - **ISSUE:** assert `o_bq_start` for one cycle; `o_bq_band`, `o_bq_x` and the coefficients are driven from `band`. Go to WAIT.
  - **WAIT:** on `i_bq_done`, `acc <= acc + i_bq_y * gain[band]`. This is a signed 16 × unsigned 8 product into a 27-bit signed accumulator, with no overflow possible for 8 bands. Then:
    - if `band == NUM_BANDS-1`, go to FINISH;
    - otherwise `band++` and go to ISSUE.
  - **FINISH:** `audio_out <= sat16(acc >>> 7)`, using an arithmetic shift with truncation. Saturation clamps to +32767 / −32768. Pulse `o_out_valid` and go to IDLE.
- **Outputs while not issuing.** `o_bq_*` data outputs are held at the last band's values; only `o_bq_start` signals a request.
- **Overrun.** `lrclk_negedge` outside IDLE sets `o_overrun`. That sample is dropped and the current sequence is unaffected.
- **Spurious done.** `i_bq_done` outside WAIT is ignored.

## Timing
- **Reset values:**
  - state IDLE;
  - `audio_out` = 0;
  - `o_out_valid`, `o_bq_start`, `o_overrun` = 0;
  - `o_bq_band` = 0, `o_bq_x` = 0;
  - all coefficients and gains, shadow and active, = 0.
- **Strobe to first request:** strobe in cycle 0 gives `o_bq_start` in cycle 1.
- **Per band:** `i_bq_done` in cycle d gives the next `o_bq_start` in cycle d+1.
- **End of sequence:** the final `i_bq_done` in cycle d gives `audio_out` / `o_out_valid` in cycle d+2.
- **Total latency:** 2 + NUM_BANDS·(L+1) cycles, where L = core start-to-done latency. It must be smaller than the sample period; otherwise overrun.
- **Reset mid-sequence:** reset asserted in any state returns everything to the reset values immediately. The core is not notified; the system resets it with the same `i_rst_n`.

## Structure
- **Package `eq_pkg`:**
  - `NUM_BANDS`, `COEF_W`, `DATA_W`, `GAIN_W` defaults;
  - `ACC_W` = 27;
  - state enum `eq_state_t`;
  - `cfg_sel_t` encodings (CFG_B1..CFG_GAIN);
  - `sat16` function.
- **Sub-module `eq_coef_bank`:** shadow/active register arrays, config decode, `load` input, and read mux indexed by band.
- **Top module:** FSM, accumulator, output register.

## Test plan
- **Single band, unity path.** Band 0 gain = 128; other gains 0; core model y = x, L = 3; `audio_in` = 1000. Required: `audio_out` = 1000; `o_out_valid` 2 cycles after the 5th done; `o_bq_band` sequence 0,1,2,3,4.
- **Positive saturation.** Gains 128 on bands 0 and 1, y = x, `audio_in` = 20000. Required: `audio_out` = 32767. With `audio_in` = −20000: `audio_out` = −32768.
- **Coefficient shadowing.** Write b1 = 0x10000 for band 2 while in WAIT. Required: the current sample's `o_b1` for band 2 is still the old value; the next sample shows 0x10000.
- **Overrun.** Core L = 100, `NUM_BANDS` = 5, strobe every 200 cycles. Required: `o_overrun` = 1 after the 2nd strobe; the first sample completes correctly.
- **Reset mid-WAIT.** Assert `i_rst_n` = 0 at band 2. Required: all outputs at reset values the same cycle; after release, the next strobe starts at band 0.
- **Invalid config and gating.** Write with `i_cfg_band` = 7 at `NUM_BANDS` = 5: no state change. `lrclk_negedge` with `i_valid` = 0: no `o_bq_start`.
